// File: rtl/seq_pkg.sv
// seq_pkg: shared definitions for the program sequencer.
//   state_t      - sequencer FSM state (IDLE, RUN, DONE)
//   *_DEF        - default values for the seq_ctrl / seq_jlut parameters
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int PC_W_DEF   = 12;
  localparam int JPTR_W_DEF = 5;
  localparam int STK_D_DEF  = 4;

endpackage

// File: rtl/seq_jlut.sv
// seq_jlut: jump look-up table, 2**JPTR_W entries of PC_W bits.
// Ports:
//   clk, reset        - clock, asynchronous active-high reset (clears all entries)
//   we, waddr, wdata  - synchronous write port
//   raddr, rdata      - asynchronous read port; a write to the same index in
//                       the same cycle is seen only from the next cycle
module seq_jlut
  import seq_pkg::*;
#(
  parameter int PC_W   = PC_W_DEF,
  parameter int JPTR_W = JPTR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [JPTR_W-1:0] waddr,
  input  logic [PC_W-1:0]   wdata,
  input  logic [JPTR_W-1:0] raddr,
  output logic [PC_W-1:0]   rdata
);

  localparam int DEPTH = 2 ** JPTR_W;

  logic [PC_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/seq_ctrl.sv
// seq_ctrl: program-counter sequencer with jump LUT and optional return stack.
// Build option: define SEQ_CALL_STACK_EN to enable the call/return stack
// (otherwise call acts as jen, ret acts as increment and fault is 0).
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   start               - begin a run from pc 0 (IDLE/DONE only)
//   stall               - freeze sequencer state for this cycle
//   jen, call, ret, halt - control actions, priority halt > ret > call > jen
//   jptr                - jump-LUT index used by jen/call
//   lut_we/waddr/wdata  - jump-LUT write port (active in every state)
//   pc                  - current instruction address
//   busy, done, fault   - state == RUN, state == DONE, stack error this run
module seq_ctrl
  import seq_pkg::*;
#(
  parameter int PC_W   = PC_W_DEF,
  parameter int JPTR_W = JPTR_W_DEF,
  parameter int STK_D  = STK_D_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  input  logic              jen,
  input  logic              call,
  input  logic              ret,
  input  logic              halt,
  input  logic [JPTR_W-1:0] jptr,
  input  logic              lut_we,
  input  logic [JPTR_W-1:0] lut_waddr,
  input  logic [PC_W-1:0]   lut_wdata,
  output logic [PC_W-1:0]   pc,
  output logic              busy,
  output logic              done,
  output logic              fault
);

  if (STK_D < 1) begin : g_bad_stk_d
    $error("seq_ctrl: STK_D must be at least 1");
  end

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc_q, pc_nxt, pc_inc, lut_rdata;

  seq_jlut #(
    .PC_W   (PC_W),
    .JPTR_W (JPTR_W)
  ) u_jlut (
    .clk   (clk),
    .reset (reset),
    .we    (lut_we),
    .waddr (lut_waddr),
    .wdata (lut_wdata),
    .raddr (jptr),
    .rdata (lut_rdata)
  );

  assign pc_inc = pc_q + PC_W'(1);

`ifdef SEQ_CALL_STACK_EN
  localparam int SP_W  = $clog2(STK_D + 1);
  localparam int IDX_W = (STK_D > 1) ? $clog2(STK_D) : 1;

  logic [SP_W-1:0] sp, sp_nxt;
  logic [PC_W-1:0] stack [STK_D];
  logic            push, fault_q, fault_nxt;

  // Stack entries only change on an accepted push; pop just moves sp.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STK_D; i++) stack[i] <= '0;
    end else if (push) begin
      stack[IDX_W'(sp)] <= pc_inc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp      <= '0;
      fault_q <= 1'b0;
    end else begin
      sp      <= sp_nxt;
      fault_q <= fault_nxt;
    end
  end

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pc_q  <= '0;
    end else begin
      state <= state_nxt;
      pc_q  <= pc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
`ifdef SEQ_CALL_STACK_EN
    sp_nxt    = sp;
    fault_nxt = fault_q;
    push      = 1'b0;
`endif
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = RUN;
          pc_nxt    = '0;
`ifdef SEQ_CALL_STACK_EN
          sp_nxt    = '0;
          fault_nxt = 1'b0;
`endif
        end
      end
      RUN: begin
        if (!stall) begin
          if (halt) begin
            state_nxt = DONE;
          end else if (ret) begin
`ifdef SEQ_CALL_STACK_EN
            if (sp == '0) begin
              fault_nxt = 1'b1;
              state_nxt = DONE;
            end else begin
              pc_nxt = stack[IDX_W'(sp - SP_W'(1))];
              sp_nxt = sp - SP_W'(1);
            end
`else
            pc_nxt = pc_inc;
`endif
          end else if (call) begin
`ifdef SEQ_CALL_STACK_EN
            if (sp == SP_W'(STK_D)) begin
              fault_nxt = 1'b1;
              state_nxt = DONE;
            end else begin
              push   = 1'b1;
              sp_nxt = sp + SP_W'(1);
              pc_nxt = lut_rdata;
            end
`else
            pc_nxt = lut_rdata;
`endif
          end else if (jen) begin
            pc_nxt = lut_rdata;
          end else begin
            pc_nxt = pc_inc;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign pc   = pc_q;
  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_seq_ctrl.sv
// tb_seq_ctrl: directed bench for seq_ctrl (default-width instance plus a
// PC_W=4 instance for wrap and async-reset checks). Define SEQ_CALL_STACK_EN
// to exercise the return stack.
module tb_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, stall, jen, call, ret, halt, lut_we;
  logic [4:0]  jptr, lut_waddr;
  logic [11:0] lut_wdata;
  logic [11:0] pc;
  logic        busy, done, fault;

  logic        reset4, start4;
  logic        zero1;
  logic [4:0]  zero5;
  logic [3:0]  zero4;
  logic [3:0]  pc4;
  logic        busy4, done4, fault4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_ctrl u_dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .jen(jen),
    .call(call), .ret(ret), .halt(halt), .jptr(jptr), .lut_we(lut_we),
    .lut_waddr(lut_waddr), .lut_wdata(lut_wdata), .pc(pc), .busy(busy),
    .done(done), .fault(fault)
  );

  seq_ctrl #(.PC_W(4)) u_dut4 (
    .clk(clk), .reset(reset4), .start(start4), .stall(zero1), .jen(zero1),
    .call(zero1), .ret(zero1), .halt(zero1), .jptr(zero5), .lut_we(zero1),
    .lut_waddr(zero5), .lut_wdata(zero4), .pc(pc4), .busy(busy4),
    .done(done4), .fault(fault4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; start = 0; stall = 0; jen = 0; call = 0; ret = 0; halt = 0;
    lut_we = 0; jptr = '0; lut_waddr = '0; lut_wdata = '0;
    reset4 = 1'b1; start4 = 0; zero1 = 0; zero4 = '0; zero5 = '0;
    tick(); tick();
    check("rst_pc", pc, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fault", fault, 0);
    reset = 0; reset4 = 0;

    // start, loading lut[3]=0x040 in the same cycle
    start = 1; lut_we = 1; lut_waddr = 5'd3; lut_wdata = 12'h040;
    tick();
    start = 0; lut_we = 0;
    check("start_busy", busy, 1);
    check("pc_seq0", pc, 0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("pc_seq%0d", i), pc, i);
    end

    // jump with a colliding same-index write: old value wins
    jen = 1; jptr = 5'd3; lut_we = 1; lut_waddr = 5'd3; lut_wdata = 12'h080;
    tick();
    jen = 0; lut_we = 0;
    check("jen_old", pc, 12'h040);
    tick();
    check("jen_inc", pc, 12'h041);
    jen = 1; jptr = 5'd3;
    tick();
    jen = 0;
    check("jen_new", pc, 12'h080);

    // LUT write during stall; jen ignored while stalled
    stall = 1; jen = 1; jptr = 5'd4; lut_we = 1; lut_waddr = 5'd4; lut_wdata = 12'h0AA;
    tick();
    stall = 0; lut_we = 0;
    check("stall_pc", pc, 12'h080);
    tick();
    jen = 0;
    check("stall_wr", pc, 12'h0AA);

    // start ignored in RUN
    start = 1;
    tick();
    start = 0;
    check("start_ign", pc, 12'h0AB);

    lut_we = 1; lut_waddr = 5'd1; lut_wdata = 12'h100;
    tick();
    lut_waddr = 5'd2; lut_wdata = 12'h010;
    tick();
    lut_we = 0;
    jen = 1; jptr = 5'd2;
    tick();
    jen = 0;
    check("goto_010", pc, 12'h010);

    call = 1; jptr = 5'd1;
    tick();
    call = 0;
    check("call_pc", pc, 12'h100);
`ifdef SEQ_CALL_STACK_EN
    for (int i = 0; i < 5; i++) tick();
    check("pre_ret", pc, 12'h105);
    ret = 1;
    tick();
    ret = 0;
    check("ret_pc", pc, 12'h011);
`else
    ret = 1;
    tick();
    ret = 0;
    check("ret_inc", pc, 12'h101);
    check("ret_nofault", fault, 0);
`endif

    // stall masks halt
    begin
      logic [11:0] held;
      held = pc;
      stall = 1; halt = 1;
      for (int i = 0; i < 3; i++) begin
        tick();
        check($sformatf("stall_hold%0d", i), pc, held);
      end
      check("stall_busy", busy, 1);
      check("stall_done", done, 0);
      stall = 0;
      tick();
      halt = 0;
      check("halt_done", done, 1);
      check("halt_busy", busy, 0);
      check("halt_pc", pc, held);
      tick();
      check("done_sticky", done, 1);
    end

    // nested calls
    start = 1;
    tick();
    start = 0;
    check("restart_pc", pc, 0);
    call = 1; jptr = 5'd1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("ncall%0d", i), pc, 12'h100);
      check($sformatf("ncall_f%0d", i), fault, 0);
    end
    tick();
    call = 0;
`ifdef SEQ_CALL_STACK_EN
    check("ovf_fault", fault, 1);
    check("ovf_done", done, 1);
    check("ovf_pc", pc, 12'h100);
    tick();
    check("fault_sticky", fault, 1);
    start = 1;
    tick();
    start = 0;
    check("clr_fault", fault, 0);
    check("clr_pc", pc, 0);
    check("clr_busy", busy, 1);
`else
    check("call5_fault", fault, 0);
    check("call5_busy", busy, 1);
    check("call5_pc", pc, 12'h100);
`endif

    // asynchronous reset mid-run clears state and LUT
    tick();
    #2 reset = 1;
    #1;
    check("arst_pc", pc, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_fault", fault, 0);
    #1 reset = 0;
    tick();
    start = 1;
    tick();
    start = 0;
    jen = 1; jptr = 5'd3;
    tick();
    jen = 0;
    check("lut_cleared", pc, 0);

    // PC_W=4 instance: wrap and async reset
    start4 = 1;
    tick();
    start4 = 0;
    check("w4_start", pc4, 0);
    check("w4_busy", busy4, 1);
    for (int i = 0; i < 15; i++) tick();
    check("w4_pc15", pc4, 15);
    tick();
    check("w4_wrap", pc4, 0);
    for (int i = 0; i < 7; i++) tick();
    check("w4_pc7", pc4, 7);
    #2 reset4 = 1;
    #1;
    check("w4_rst_pc", pc4, 0);
    check("w4_rst_busy", busy4, 0);
    check("w4_fault", fault4, 0);
    #1 reset4 = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
